ifetch_unit: RTL

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_unit.sv | 95 +++++++++
 1 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: sequential PC generation feeding a DEPTH-entry prefetch FIFO.
// Optional misaligned-redirect flag is built when IFETCH_MISALIGN_CHK_EN is defined.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        misalign_err
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  logic [31:0]     r_fetch_pc;
  logic [31:0]     r_instr [DEPTH];
  logic [31:0]     r_pc    [DEPTH];
  logic [PtrW-1:0] r_rptr;
  logic [PtrW-1:0] r_wptr;
  logic [CntW-1:0] r_count;
  logic            w_enq;
  logic            w_deq;

  assign imem_addr = r_fetch_pc;
  assign out_valid = (r_count != '0) && !redirect;
  assign w_deq     = out_valid && out_ready;
  // A full buffer still accepts a new word when the head leaves in the same cycle.
  assign w_enq     = !redirect && ((r_count < FullCnt) || w_deq);
  assign out_instr = r_instr[r_rptr];
  assign out_pc    = r_pc[r_rptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_pc <= RESET_PC;
      r_rptr     <= '0;
      r_wptr     <= '0;
      r_count    <= '0;
    end else if (redirect) begin
      r_fetch_pc <= {redirect_pc[31:2], 2'b00};
      r_rptr     <= '0;
      r_wptr     <= '0;
      r_count    <= '0;
    end else begin
      if (w_enq) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
        r_wptr     <= r_wptr + PtrW'(1);
      end
      if (w_deq) begin
        r_rptr <= r_rptr + PtrW'(1);
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset: entries are only visible through r_count.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_instr[r_wptr] <= imem_rd;
      r_pc[r_wptr]    <= r_fetch_pc;
    end
  end

`ifdef IFETCH_MISALIGN_CHK_EN
  logic r_misalign_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_misalign_err <= 1'b0;
    end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
      r_misalign_err <= 1'b1;
    end
  end

  assign misalign_err = r_misalign_err;
`else
  logic w_unused_pc_lsb;

  assign w_unused_pc_lsb = ^redirect_pc[1:0];
  assign misalign_err    = 1'b0;
`endif

endmodule
